// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: states, opcodes,
// ALUOp codes and ALU operand selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_REG   = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

endpackage

// File: rtl/mc_instret_counter.sv
// Retired-instruction counter: increments by one on each cycle inc is high,
// wraps modulo 2^CNT_W, no backpressure.
module mc_instret_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM: R/I 4 cycles, branch 3, load 5, store 4 with memory ready;
// each mem_ready-low cycle in FETCH/MEM_READ/MEM_WRITE stretches the instruction by one.
module multi_cycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             iord,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic             illegal_inst,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  state_t state, state_nxt;
  logic   retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_REG;
    ALUOp        = ALUOP_ADD;
    illegal_inst = 1'b0;
    retire       = 1'b0;
    state_nxt    = S_FETCH;

    case (state)
      S_FETCH: begin
        mem_read  = run;
        alu_src_b = SRCB_FOUR;
        if (run && mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here from the old PC into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
          OP_RTYPE:          state_nxt = S_EXEC_R;
          OP_ITYPE:          state_nxt = S_EXEC_I;
          OP_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE)
              state_nxt = S_BRANCH;
            else
              illegal_inst = 1'b1;
          end
          default: illegal_inst = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        state_nxt = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        iord      = 1'b1;
        mem_read  = 1'b1;
        state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = mem_ready;
        state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        ALUOp     = ALUOP_RTYPE;
        state_nxt = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        ALUOp     = ALUOP_ITYPE;
        state_nxt = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        ALUOp     = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = (funct3 == F3_BNE) ? ~zero_flag : zero_flag;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Controls are masked combinationally so an in-flight access dies with reset.
    if (reset) begin
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      alu_src_a    = SRCA_PC;
      alu_src_b    = SRCB_REG;
      ALUOp        = ALUOP_ADD;
      illegal_inst = 1'b0;
      retire       = 1'b0;
    end
  end

  assign state_dbg = state;

  mc_instret_counter #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk  (clk),
    .rst  (reset),
    .inc  (retire),
    .count(instret)
  );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller: per-cycle state and control-vector
// checks against hand-computed values, plus retire-count checks.
module tb_multi_cycle_controller;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero_flag;
  logic        mem_ready;
  logic        pc_write, pc_src, iord, ir_write, mem_read, mem_write;
  logic        reg_write, mem_to_reg, illegal_inst;
  logic [1:0]  alu_src_a, alu_src_b, ALUOp;
  logic [31:0] instret;
  logic [3:0]  state_dbg;
  logic [14:0] ctl_obs;

  int n_chk  = 0;
  int n_pass = 0;

  multi_cycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct3(funct3),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .illegal_inst(illegal_inst), .instret(instret),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign ctl_obs = {pc_write, pc_src, iord, ir_write, mem_read, mem_write,
                    reg_write, mem_to_reg, alu_src_a, alu_src_b, ALUOp, illegal_inst};

  // Field order: pcw pcs iord irw mrd mwr rw m2r srca srcb aluop ill
  localparam logic [14:0] C_ZERO   = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [14:0] C_F_GO   = 15'b1_0_0_1_1_0_0_0_00_01_00_0;
  localparam logic [14:0] C_F_WAIT = 15'b0_0_0_0_1_0_0_0_00_01_00_0;
  localparam logic [14:0] C_F_IDLE = 15'b0_0_0_0_0_0_0_0_00_01_00_0;
  localparam logic [14:0] C_DEC    = 15'b0_0_0_0_0_0_0_0_01_10_00_0;
  localparam logic [14:0] C_DEC_IL = 15'b0_0_0_0_0_0_0_0_01_10_00_1;
  localparam logic [14:0] C_EXR    = 15'b0_0_0_0_0_0_0_0_10_00_10_0;
  localparam logic [14:0] C_EXI    = 15'b0_0_0_0_0_0_0_0_10_10_11_0;
  localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [14:0] C_MADDR  = 15'b0_0_0_0_0_0_0_0_10_10_00_0;
  localparam logic [14:0] C_MRD    = 15'b0_0_1_0_1_0_0_0_00_00_00_0;
  localparam logic [14:0] C_MWB    = 15'b0_0_0_0_0_0_1_1_00_00_00_0;
  localparam logic [14:0] C_MWR    = 15'b0_0_1_0_0_1_0_0_00_00_00_0;
  localparam logic [14:0] C_BR_T   = 15'b1_1_0_0_0_0_0_0_10_00_01_0;
  localparam logic [14:0] C_BR_N   = 15'b0_1_0_0_0_0_0_0_10_00_01_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] ctl);
    @(negedge clk);
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".ctl"}, 32'(ctl_obs), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [6:0] op, input logic [2:0] f3, input logic z);
    opcode    = op;
    funct3    = f3;
    zero_flag = z;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1;
    set_inst(7'd0, 3'd0, 1'b0);
    @(negedge clk);
    check("rst.state", 32'(state_dbg), 32'(S_FETCH));
    check("rst.ctl", 32'(ctl_obs), 32'(C_ZERO));
    check("rst.instret", instret, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add x2,x1,x2 (0x00208133)
    set_inst(7'b0110011, 3'b000, 1'b0);
    cyc("add.c1", S_FETCH, C_F_GO);
    cyc("add.c2", S_DECODE, C_DEC);
    cyc("add.c3", S_EXEC_R, C_EXR);
    check("add.instret_pre", instret, 32'd0);
    cyc("add.c4", S_ALU_WB, C_ALUWB);
    check("add.instret", instret, 32'd1);

    set_inst(7'b0010011, 3'b000, 1'b0);
    cyc("addi.c1", S_FETCH, C_F_GO);
    cyc("addi.c2", S_DECODE, C_DEC);
    cyc("addi.c3", S_EXEC_I, C_EXI);
    cyc("addi.c4", S_ALU_WB, C_ALUWB);
    check("addi.instret", instret, 32'd2);

    // Load, mem_ready stays high through DECODE/MEM_ADDR then low 3 cycles.
    set_inst(7'b0000011, 3'b010, 1'b0);
    cyc("lw.c1", S_FETCH, C_F_GO);
    cyc("lw.c2", S_DECODE, C_DEC);
    cyc("lw.c3", S_MEM_ADDR, C_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.wait", S_MEM_READ, C_MRD);
    mem_ready = 1'b1;
    cyc("lw.c7", S_MEM_READ, C_MRD);
    cyc("lw.c8", S_MEM_WB, C_MWB);
    check("lw.instret", instret, 32'd3);

    set_inst(7'b0100011, 3'b010, 1'b0);
    cyc("sw.c1", S_FETCH, C_F_GO);
    cyc("sw.c2", S_DECODE, C_DEC);
    cyc("sw.c3", S_MEM_ADDR, C_MADDR);
    mem_ready = 1'b0;
    cyc("sw.wait", S_MEM_WRITE, C_MWR);
    check("sw.instret_hold", instret, 32'd3);
    mem_ready = 1'b1;
    cyc("sw.c5", S_MEM_WRITE, C_MWR);
    check("sw.instret", instret, 32'd4);

    // BEQ taken, with one stalled fetch cycle first.
    set_inst(7'b1100011, 3'b000, 1'b1);
    mem_ready = 1'b0;
    cyc("beq1.fwait", S_FETCH, C_F_WAIT);
    mem_ready = 1'b1;
    cyc("beq1.c1", S_FETCH, C_F_GO);
    cyc("beq1.c2", S_DECODE, C_DEC);
    cyc("beq1.c3", S_BRANCH, C_BR_T);
    check("beq1.instret", instret, 32'd5);

    set_inst(7'b1100011, 3'b000, 1'b0);
    cyc("beq0.c1", S_FETCH, C_F_GO);
    cyc("beq0.c2", S_DECODE, C_DEC);
    cyc("beq0.c3", S_BRANCH, C_BR_N);
    check("beq0.instret", instret, 32'd6);

    set_inst(7'b1100011, 3'b001, 1'b1);
    cyc("bne1.c1", S_FETCH, C_F_GO);
    cyc("bne1.c2", S_DECODE, C_DEC);
    cyc("bne1.c3", S_BRANCH, C_BR_N);
    check("bne1.instret", instret, 32'd7);

    set_inst(7'b1100011, 3'b001, 1'b0);
    cyc("bne0.c1", S_FETCH, C_F_GO);
    cyc("bne0.c2", S_DECODE, C_DEC);
    cyc("bne0.c3", S_BRANCH, C_BR_T);
    check("bne0.instret", instret, 32'd8);

    set_inst(7'h7F, 3'b000, 1'b0);
    cyc("ill.c1", S_FETCH, C_F_GO);
    cyc("ill.c2", S_DECODE, C_DEC_IL);
    set_inst(7'b1100011, 3'b010, 1'b0);
    cyc("illbr.c1", S_FETCH, C_F_GO);
    cyc("illbr.c2", S_DECODE, C_DEC_IL);
    check("ill.instret", instret, 32'd8);

    // run low: mem_ready must be ignored and FETCH held.
    run = 1'b0;
    cyc("idle.c1", S_FETCH, C_F_IDLE);
    cyc("idle.c2", S_FETCH, C_F_IDLE);
    run = 1'b1;
    set_inst(7'b0110011, 3'b000, 1'b0);
    cyc("resume.c1", S_FETCH, C_F_GO);
    cyc("resume.c2", S_DECODE, C_DEC);
    cyc("resume.c3", S_EXEC_R, C_EXR);
    cyc("resume.c4", S_ALU_WB, C_ALUWB);
    check("resume.instret", instret, 32'd9);

    // Reset in the middle of a stalled store.
    set_inst(7'b0100011, 3'b000, 1'b0);
    cyc("swr.c1", S_FETCH, C_F_GO);
    cyc("swr.c2", S_DECODE, C_DEC);
    cyc("swr.c3", S_MEM_ADDR, C_MADDR);
    mem_ready = 1'b0;
    @(negedge clk);
    check("swr.mem_write_pre", 32'(mem_write), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("swr.mem_write_rst", 32'(mem_write), 32'd0);
    check("swr.state_rst", 32'(state_dbg), 32'(S_FETCH));
    check("swr.instret_rst", instret, 32'd0);
    check("swr.ctl_rst", 32'(ctl_obs), 32'(C_ZERO));
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    cyc("post.c1", S_FETCH, C_F_GO);
    cyc("post.c2", S_DECODE, C_DEC);
    cyc("post.c3", S_MEM_ADDR, C_MADDR);
    cyc("post.c4", S_MEM_WRITE, C_MWR);
    check("post.instret", instret, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Moore/Mealy control FSM that sequences a multi-cycle RV32I-subset datapath built from the existing single-cycle units: ALU, register file, immediate generator, PC and one unified instruction/data memory. The single-cycle Control Unit decodes each instruction in one cycle. This block instead steps each instruction through fetch, decode, execute, memory and writeback states. It also waits on a variable-latency memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
run  input  1  fetch enable; sampled only in FETCH.
opcode  input  7  instruction register bits [6:0].
funct3  input  3  instruction register bits [14:12].
zero_flag  input  1  ALU zero output.
mem_ready  input  1  memory access complete this cycle.
pc_write  output  1  load PC.
pc_src  output  1  0 = ALU result, 1 = ALUOut register.
iord  output  1  memory address: 0 = PC, 1 = ALUOut.
ir_write  output  1  load instruction register.
mem_read  output  1  memory read request.
mem_write  output  1  memory write request.
reg_write  output  1  register file write enable.
mem_to_reg  output  1  writeback source: 0 = ALUOut, 1 = memory data register.
alu_src_a  output  2  0 = PC, 1 = old PC, 2 = rs1 register A.
alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = immediate.
ALUOp  output  2  00 = add, 01 = sub, 10 = R-type funct decode, 11 = I-type funct decode.
illegal_inst  output  1  one-cycle pulse on an unsupported opcode or funct3.
instret  output  CNT_W  retired-instruction count.
state_dbg  output  4  current state encoding.

Behaviour:
- Reset (asynchronous): state = FETCH, instret = 0. While reset is high, every control output is forced to 0.
- Default: every output not listed for a state is 0.
- FETCH:
  - Drives mem_read = run, iord = 0, alu_src_a = 0, alu_src_b = 1, ALUOp = 00.
  - If run && mem_ready: ir_write = 1, pc_write = 1, pc_src = 0 (Mealy), then go to DECODE.
  - Otherwise hold FETCH. If run = 0, mem_read is 0 and mem_ready is ignored.
- DECODE: alu_src_a = 1, alu_src_b = 2, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR.
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 1100011 with funct3 000 or 001 -> BRANCH.
  - Anything else -> FETCH with illegal_inst = 1 for that cycle and no retire. PC already holds PC+4.
- MEM_ADDR: alu_src_a = 2, alu_src_b = 2, ALUOp = 00. Load goes to MEM_READ, store goes to MEM_WRITE.
- MEM_READ: iord = 1, mem_read = 1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1. Go to FETCH and retire.
- MEM_WRITE: iord = 1, mem_write = 1. Hold until mem_ready, then go to FETCH and retire.
- EXEC_R: alu_src_a = 2, alu_src_b = 0, ALUOp = 10. Go to ALU_WB.
- EXEC_I: alu_src_a = 2, alu_src_b = 2, ALUOp = 11. Go to ALU_WB.
- ALU_WB: reg_write = 1, mem_to_reg = 0. Go to FETCH and retire.
- BRANCH: alu_src_a = 2, alu_src_b = 0, ALUOp = 01, pc_src = 1.
  - pc_write = zero_flag for BEQ (funct3 000), ~zero_flag for BNE (funct3 001).
  - Go to FETCH and retire whether or not the branch is taken.
- Retire: instret increments by 1 on the edge leaving MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with mem_ready. It wraps modulo 2^CNT_W.
- Latency with mem_ready tied to 1: R/I-type 4 cycles, branch 3, load 5, store 4. Each extra mem_ready-low cycle adds one cycle.
- mem_ready high in a state with no memory request is ignored.
- Reset asserted mid-access drops mem_read and mem_write immediately and loses the access.
- Encoding: state fits in 4 bits; unused encodings recover to FETCH on the next edge.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings;
  - opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH);
  - ALUOp codes;
  - alu_src_a / alu_src_b select codes.
- Sub-module mc_instret_counter: CNT_W-bit counter with async reset and inc input.
- FSM next-state logic and output decode remain in the top module.

Test Plan:
- R-type add x2,x1,x2 (0x00208133), mem_ready = 1, run = 1 -> state_dbg FETCH, DECODE, EXEC_R, ALU_WB. reg_write high only in cycle 4, ALUOp = 10 in cycle 3, instret 0 -> 1.
- Load (opcode 0000011) with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with iord = 1 and mem_read = 1, then MEM_WB with mem_to_reg = 1; 8 cycles total.
- Branch: BEQ with zero_flag = 1 -> pc_write = 1, pc_src = 1 in BRANCH. BEQ with zero_flag = 0 -> pc_write = 0. BNE inverts both. instret increments in all cases.
- Opcode 0x7F -> illegal_inst pulses in the DECODE cycle, next state FETCH, instret unchanged.
- Reset asserted during MEM_WRITE -> mem_write = 0 in the same cycle, state_dbg = FETCH, instret = 0. After release, the FETCH sequence restarts.
- run = 0 in FETCH with mem_ready = 1 -> mem_read = 0, ir_write = 0, state held. Raising run resumes fetch.
